// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared widths, op encoding and result-flag bundle for the add64 pipeline
package add_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } res_flags_t;

endpackage

// File: rtl/add64_core.sv
// rtl/add64_core.sv - combinational carry-select adder
//
// Ports:
//   c_out  carry out of the MSB
//   sum    a + b + c_in modulo 2^W
//   a, b   operands
//   c_in   carry in
module add64_core #(
    parameter int W   = 64,
    parameter int BLK = 16
) (
    output logic         c_out,
    output logic [W-1:0] sum,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in
);

    localparam int NB = W / BLK;

    logic [NB:0] carry;

    assign carry[0] = c_in;

    // Each block precomputes its result for both possible incoming carries;
    // the ripple between blocks is then just a chain of muxes.
    for (genvar i = 0; i < NB; i++) begin : g_blk
        logic [BLK:0] r0;
        logic [BLK:0] r1;

        assign r0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
        assign r1 = r0 + {{BLK{1'b0}}, 1'b1};

        assign sum[i*BLK +: BLK] = carry[i] ? r1[BLK-1:0] : r0[BLK-1:0];
        assign carry[i+1]        = carry[i] ? r1[BLK]     : r0[BLK];
    end

    assign c_out = carry[NB];

endmodule

// File: rtl/add64_pipe.sv
// rtl/add64_pipe.sv - two-stage registered add/subtract pipeline with valid/ready on both sides
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand beat handshake
//   in_a, in_b              operands
//   in_cin                  carry in (ignored for subtract)
//   in_sub                  1 = A - B
//   out_valid/out_ready     result beat handshake
//   out_sum                 result
//   out_cout                carry out (subtract: 1 = no borrow)
//   out_ovf                 signed overflow
//   out_zero                out_sum == 0
//   ops_done                count of results handed off (wraps)
module add64_pipe
    import add_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_zero,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic              s1_cin;
    logic              s1_valid;
    logic              s1_ready;
    logic              s2_ready;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    res_flags_t        nxt_flags;

    logic [DATA_W-1:0] s2_sum;
    res_flags_t        s2_flags;

    // S2 frees up when empty or draining; S1 may then refill in the same cycle.
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Subtract is folded into the operand capture so the adder only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= in_a;
                s1_b   <= (in_sub == OP_SUB) ? ~in_b : in_b;
                s1_cin <= (in_sub == OP_SUB) ? 1'b1  : in_cin;
            end
        end
    end

    add64_core #(
        .W (DATA_W)
    ) u_core (
        .c_out (add_cout),
        .sum   (add_sum),
        .a     (s1_a),
        .b     (s1_b),
        .c_in  (s1_cin)
    );

    always_comb begin
        nxt_flags      = '0;
        nxt_flags.cout = add_cout;
        nxt_flags.ovf  = (s1_a[MSB] == s1_b[MSB]) && (add_sum[MSB] != s1_a[MSB]);
        nxt_flags.zero = (add_sum == '0);
    end

    // Data only loads on a real beat so a bubble leaves the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s2_sum    <= '0;
            s2_flags  <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= add_sum;
                s2_flags <= nxt_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (out_valid && out_ready) begin
            ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_sum  = s2_sum;
    assign out_cout = s2_flags.cout;
    assign out_ovf  = s2_flags.ovf;
    assign out_zero = s2_flags.zero;

endmodule

// File: tb/tb_add64_pipe.sv
// tb/tb_add64_pipe.sv - self-checking scoreboard bench for add64_pipe
`timescale 1ns/1ps
module tb_add64_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  ops_done;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb[$];
    logic [3:0]  ops_model;
    logic        mon_en;
    logic        hold_pending;
    exp_t        held;

    add64_pipe #(.DATA_W(64), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        exp_t               e;
        logic [64:0]        full;
        logic signed [65:0] sr;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            e.cout = ~full[64];
            sr     = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {64'b0, cin};
            e.cout = full[64];
            sr     = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'b0, cin});
        end
        e.sum  = full[63:0];
        e.ovf  = (sr[65:63] != {3{sr[63]}});
        e.zero = (e.sum == 64'd0);
        return e;
    endfunction

    // Scoreboard monitor: samples at the falling edge what will transfer at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (hold_pending) begin
                n_checks++;
                if (!out_valid || out_sum !== held.sum || out_cout !== held.cout ||
                    out_ovf !== held.ovf || out_zero !== held.zero) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b sum=%h c=%0b o=%0b z=%0b expected v=1 sum=%h c=%0b o=%0b z=%0b",
                             out_valid, out_sum, out_cout, out_ovf, out_zero,
                             held.sum, held.cout, held.ovf, held.zero);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = '{out_sum, out_cout, out_ovf, out_zero};

            n_checks++;
            if (ops_done !== ops_model) begin
                n_fail++;
                $display("FAIL ops_done_track: got %0d expected %0d", ops_done, ops_model);
            end

            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got sum=%h expected no result", out_sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf || out_zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL scoreboard: got sum=%h c=%0b o=%0b z=%0b expected sum=%h c=%0b o=%0b z=%0b",
                                 out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
                ops_model = ops_model + 4'd1;
            end

            if (in_valid && in_ready)
                sb.push_back(model(in_a, in_b, in_cin, in_sub));
        end
    end

    task automatic clear_model();
        sb.delete();
        ops_model    = 4'd0;
        hold_pending = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds the beat until accepted; returns 1 ns after the accepting edge with in_valid still high.
    task automatic drive_beat(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        int   cyc;
        logic acc;
        cyc = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 100);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", cyc);
        end
    endtask

    task automatic single_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                             output logic v_early, output logic v, output exp_t r);
        out_ready = 1'b1;
        drive_beat(a, b, cin, sub);
        in_valid = 1'b0;
        v_early = out_valid;
        @(posedge clk);
        #1;
        v = out_valid;
        r = '{out_sum, out_cout, out_ovf, out_zero};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0 ||
            out_zero !== 1'b0 || ops_done !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got v=%0b sum=%h c=%0b o=%0b z=%0b ops=%0d rdy=%0b expected all 0, rdy=1",
                     out_valid, out_sum, out_cout, out_ovf, out_zero, ops_done, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got rdy=%0b v=%0b expected rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_carry();
        logic v_early, v;
        exp_t r;
        single_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, v_early, v, r);
        n_checks++;
        if (v_early !== 1'b0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: got valid after N=%0b after N+1=%0b expected 0 then 1", v_early, v);
        end
        n_checks++;
        if (r.sum !== 64'd0 || r.cout !== 1'b1 || r.zero !== 1'b1 || r.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL add_carry: got sum=%h c=%0b o=%0b z=%0b expected sum=0 c=1 o=0 z=1",
                     r.sum, r.cout, r.ovf, r.zero);
        end
    endtask

    task automatic test_overflow();
        logic v_early, v;
        exp_t r;
        single_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, v_early, v, r);
        n_checks++;
        if (v !== 1'b1 || r.sum !== 64'h8000_0000_0000_0000 || r.ovf !== 1'b1 || r.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ovf: got v=%0b sum=%h o=%0b c=%0b expected v=1 sum=8000000000000000 o=1 c=0",
                     v, r.sum, r.ovf, r.cout);
        end
        single_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, v_early, v, r);
        n_checks++;
        if (v !== 1'b1 || r.sum !== 64'h7FFF_FFFF_FFFF_FFFF || r.ovf !== 1'b1 || r.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_ovf: got v=%0b sum=%h o=%0b c=%0b expected v=1 sum=7fffffffffffffff o=1 c=1",
                     v, r.sum, r.ovf, r.cout);
        end
    endtask

    task automatic test_sub();
        logic v_early, v;
        exp_t r;
        single_op(64'd10, 64'd3, 1'b0, 1'b1, v_early, v, r);
        n_checks++;
        if (r.sum !== 64'd7 || r.cout !== 1'b1 || r.ovf !== 1'b0 || r.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_pos: got sum=%h c=%0b o=%0b z=%0b expected sum=7 c=1 o=0 z=0",
                     r.sum, r.cout, r.ovf, r.zero);
        end
        single_op(64'd3, 64'd10, 1'b0, 1'b1, v_early, v, r);
        n_checks++;
        if (r.sum !== 64'hFFFF_FFFF_FFFF_FFF9 || r.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_neg: got sum=%h c=%0b expected sum=fffffffffffffff9 c=0", r.sum, r.cout);
        end
        // cin must be ignored for subtract
        single_op(64'd5, 64'd5, 1'b1, 1'b1, v_early, v, r);
        n_checks++;
        if (r.sum !== 64'd0 || r.zero !== 1'b1 || r.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_cin_ignored: got sum=%h z=%0b c=%0b expected sum=0 z=1 c=1", r.sum, r.zero, r.cout);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ba[5];
        logic [63:0] bb[5];
        logic [3:0]  ops0;
        exp_t        e0;
        int          acc, outs, cyc, first_out, last_out;
        for (int k = 0; k < 5; k++) begin
            ba[k] = {$urandom, $urandom};
            bb[k] = {$urandom, $urandom};
        end
        e0 = model(ba[0], bb[0], 1'b0, 1'b0);
        ops0 = ops_model;
        acc = 0; outs = 0; cyc = 0; first_out = -1; last_out = -1;
        while (outs < 5 && cyc < 60) begin
            out_ready = (cyc >= 6);
            in_valid  = (acc < 5);
            if (acc < 5) begin
                in_a = ba[acc]; in_b = bb[acc]; in_cin = 1'b0; in_sub = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 2 && cyc < 6) begin
                n_checks++;
                if (in_ready !== 1'b0 || acc !== 2 || out_sum !== e0.sum) begin
                    n_fail++;
                    $display("FAIL bp_stall: cyc=%0d got rdy=%0b acc=%0d sum=%h expected rdy=0 acc=2 sum=%h",
                             cyc, in_ready, acc, out_sum, e0.sum);
                end
            end
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                outs++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (outs !== 5 || first_out !== 6 || last_out !== 10) begin
            n_fail++;
            $display("FAIL bp_drain: got outs=%0d first=%0d last=%0d expected outs=5 first=6 last=10",
                     outs, first_out, last_out);
        end
        n_checks++;
        if (ops_done !== ops0 + 4'd5) begin
            n_fail++;
            $display("FAIL bp_ops_done: got %0d expected %0d", ops_done, ops0 + 4'd5);
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b0;
        drive_beat(64'd100, 64'd200, 1'b0, 1'b0);
        drive_beat(64'd300, 64'd400, 1'b1, 1'b0);
        in_valid = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ops_done !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got v=%0b ops=%0d rdy=%0b expected v=0 ops=0 rdy=1",
                     out_valid, ops_done, in_ready);
        end
        clear_model();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_flush: got %0d valid cycles expected 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_counter_wrap();
        int acc, outs, cyc;
        apply_reset();
        acc = 0; outs = 0; cyc = 0;
        while (outs < 17 && cyc < 3000) begin
            in_valid  = (acc < 17) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a   = {$urandom, $urandom};
            in_b   = ($urandom_range(0, 3) == 0) ? ~in_a : {$urandom, $urandom};
            in_cin = $urandom_range(0, 1);
            in_sub = $urandom_range(0, 1);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) outs++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (outs !== 17 || ops_done !== 4'd1) begin
            n_fail++;
            $display("FAIL counter_wrap: got outs=%0d ops=%0d expected outs=17 ops=1", outs, ops_done);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        mon_en    = 1'b1;
        ops_model = 4'd0;
        hold_pending = 1'b0;
        held      = '0;
        test_reset();
        test_add_carry();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_midstream();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
